// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Parametrised multi-read, single-write register file with optional
//   write-to-read bypass, per-byte write enables and a hardware bulk-clear
//   sequencer with a busy/done handshake. Sits between instruction decode
//   (read addresses) and writeback (write port).
//
// Parameters
//   DATA_W      register width in bits (multiple of 8)
//   DEPTH       number of registers (power of two, >= 2)
//   ADDR_W      address width, $clog2(DEPTH)
//   NUM_RD      number of read ports (1..4)
//   RESET_VALUE value loaded by reset and by bulk clear
//   BYPASS      1 = same-cycle write data forwarded to matching read ports
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   rd_addr     packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     packed read data, port i at [i*DATA_W +: DATA_W] (combinational)
//   wr_en       write request
//   wr_addr     write address
//   wr_data     write data
//   wr_be       byte enables, bit b covers bits [8b+7:8b]
//   clear_req   bulk-clear request, sampled on the clock edge
//   clear_busy  clear sequencer active; writes are dropped while high
//   clear_done  one-cycle pulse when the clear completes
//
// Optional feature
//   REGFILE_R0_ZERO_EN : when defined, register 0 is hardwired to zero
//   (writes ignored, reads and bypass return 0, reset/clear leave it at 0).
//
// Clear sequencer states
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | normal operation, waiting for clear_req
//   S_CLEAR | writing RESET_VALUE to one register per cycle, busy high
//   S_DONE  | single cycle with clear_done high, writes accepted again

module regfile_multiport #(
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 32,
  parameter int                ADDR_W      = $clog2(DEPTH),
  parameter int                NUM_RD      = 2,
  parameter logic [DATA_W-1:0] RESET_VALUE = 32'h0000_0040,
  parameter int                BYPASS      = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   wr_merged;
  logic                wr_live;
  logic                wr_commit;

  // ---------------------------------------------------------------------------
  // Clear sequencer. clear_busy/clear_done are registered alongside the state
  // so they are glitch-free; busy rises on the sampling edge and falls on the
  // edge that clears the last register, giving exactly DEPTH busy cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      clr_idx    <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clear_done <= 1'b0;
          if (clear_req) begin
            state      <= S_CLEAR;
            clr_idx    <= '0;
            clear_busy <= 1'b1;
          end
        end
        S_CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state      <= S_DONE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end
        end
        S_DONE: begin
          clear_done <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state      <= S_IDLE;
          clear_busy <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

  // A write is "live" for forwarding whenever it would be accepted by the
  // array; register 0 is additionally excluded from commit when hardwired.
  assign wr_live   = wr_en && !clear_busy;
  assign wr_commit = wr_live && !(R0_ZERO && (wr_addr == '0));

  // Byte-merge of the new data into the addressed word; shared by the
  // array update and the bypass path.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (wr_be[b]) begin
        wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage: one register per entry so each has its own reset value and the
  // clear and write paths never touch the same entry in one cycle (writes
  // are dropped while the sequencer is clearing).
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    localparam logic [DATA_W-1:0] INIT = (R0_ZERO && (g == 0)) ? '0 : RESET_VALUE;
    logic [DATA_W-1:0] q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        q <= INIT;
      end else if ((state == S_CLEAR) && (clr_idx == ADDR_W'(g))) begin
        q <= INIT;
      end else if (wr_commit && (wr_addr == ADDR_W'(g))) begin
        q <= wr_merged;
      end
    end

    assign mem[g] = q;
  end

  // ---------------------------------------------------------------------------
  // Read ports: combinational array read, optional byte-wise forwarding of
  // the in-flight write, and the register-0 override last so it wins over
  // any forwarded data.
  // ---------------------------------------------------------------------------
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      rv = mem[ra];
      if ((BYPASS != 0) && wr_live && (wr_addr == ra)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            rv[b*8 +: 8] = wr_data[b*8 +: 8];
          end
        end
      end
      if (R0_ZERO && (ra == '0)) begin
        rv = '0;
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = rv;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam logic [31:0] RV = 32'h0000_0040;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_be;
  logic          clear_req;
  logic          clear_busy;
  logic          clear_done;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model [DP];

  regfile_multiport dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_be      (wr_be),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [8];

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = be[b] ? 8'hFF : 8'h00;
    return (old & ~m) | (nw & m);
  endfunction

  // Expected read value: array contents, forwarded bytes of a live write,
  // register 0 forced to zero when the hardwired-zero option is built in.
  function automatic logic [31:0] rd_model(input logic [4:0] ra, input logic we,
      input logic busy, input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] v;
    v = model[ra];
    if (we && !busy && wa == ra) v = merge(v, wd, be);
    if (R0Z && ra == 5'd0) v = 32'h0;
    return v;
  endfunction

  function automatic void model_write(input logic we, input logic busy, input logic [4:0] wa,
                                      input logic [31:0] wd, input logic [3:0] be);
    if (we && !busy && !(R0Z && wa == 5'd0)) model[wa] = merge(model[wa], wd, be);
  endfunction

  function automatic void model_reset;
    for (int i = 0; i < DP; i++) model[i] = (R0Z && i == 0) ? 32'h0 : RV;
  endfunction

  task automatic drive_idle;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; clear_req = 1'b0;
  endtask

  task automatic check_all(input string tag);
    for (int a = 0; a < DP; a += 2) begin
      rd_addr = {5'(a + 1), 5'(a)};
      #1;
      chk($sformatf("%s_a%0d", tag, a), rd_data[31:0], rd_model(5'(a), 0, 0, 0, 0, 0));
      chk($sformatf("%s_a%0d", tag, a + 1), rd_data[63:32], rd_model(5'(a + 1), 0, 0, 0, 0, 0));
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = 4'hF;
    model_write(1'b1, 1'b0, a, d, 4'hF);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, done_cyc, bad_cnt;
    logic [4:0] ra0, ra1;
    logic [31:0] e0, e1;

    // Hand-computed table: byte masking, bypass, no-op enable, partial bytes.
    tbl[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 4'hF, 5'd5,  5'd7,  32'hDEAD_BEEF, 32'h0000_0040};
    tbl[1] = '{1'b1, 5'd5,  32'h1122_3344, 4'h5, 5'd5,  5'd5,  32'hDE22_BE44, 32'hDE22_BE44};
    tbl[2] = '{1'b0, 5'd5,  32'h0,         4'h0, 5'd5,  5'd3,  32'hDE22_BE44, 32'h0000_0040};
    tbl[3] = '{1'b1, 5'd7,  32'hA5A5_A5A5, 4'hF, 5'd7,  5'd5,  32'hA5A5_A5A5, 32'hDE22_BE44};
    tbl[4] = '{1'b1, 5'd7,  32'h0,         4'h0, 5'd7,  5'd0,  32'hA5A5_A5A5, 32'h0000_0040};
    tbl[5] = '{1'b1, 5'd31, 32'h1234_5678, 4'h8, 5'd31, 5'd7,  32'h1200_0040, 32'hA5A5_A5A5};
    tbl[6] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 4'h3, 5'd0,  5'd31, 32'h0000_FFFF, 32'h1200_0040};
    tbl[7] = '{1'b0, 5'd0,  32'h0,         4'h0, 5'd0,  5'd5,  32'h0000_FFFF, 32'hDE22_BE44};

    drive_idle();
    rd_addr = '0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_busy", {31'h0, clear_busy}, 32'h0);
    chk("rst_done", {31'h0, clear_done}, 32'h0);
    check_all("rst");

    // Table phase
    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; wr_be = tbl[i].be;
      rd_addr = {tbl[i].r1, tbl[i].r0};
      #1;
      e0 = (R0Z && tbl[i].r0 == 5'd0) ? 32'h0 : tbl[i].e0;
      e1 = (R0Z && tbl[i].r1 == 5'd0) ? 32'h0 : tbl[i].e1;
      chk($sformatf("tbl%0d_p0", i), rd_data[31:0], e0);
      chk($sformatf("tbl%0d_p1", i), rd_data[63:32], e1);
      model_write(tbl[i].we, 1'b0, tbl[i].wa, tbl[i].wd, tbl[i].be);
      tick();
    end
    drive_idle();

    // Randomised phase against the model
    for (int i = 0; i < 300; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      wr_be = 4'($urandom);
      ra0 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? wr_addr : 5'($urandom);
      rd_addr = {ra1, ra0};
      #1;
      chk($sformatf("rnd%0d_p0", i), rd_data[31:0], rd_model(ra0, wr_en, 0, wr_addr, wr_data, wr_be));
      chk($sformatf("rnd%0d_p1", i), rd_data[63:32], rd_model(ra1, wr_en, 0, wr_addr, wr_data, wr_be));
      model_write(wr_en, 1'b0, wr_addr, wr_data, wr_be);
      tick();
    end
    drive_idle();
    check_all("rnd_end");

    // Mid-simulation reset
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst_low");
    tick();
    reset_n = 1'b1;
    check_all("midrst");

    // Bulk clear
    for (int i = 0; i < DP; i++) write_reg(5'(i), 32'(i * 3));
    check_all("fill");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (clear_busy) busy_cnt++;
      if (clear_done) begin done_cnt++; done_cyc = c; end
      if (clear_busy && busy_cnt == 5) clear_req = 1'b1;
      if (clear_busy && busy_cnt == 20) begin
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFF_FFFF; wr_be = 4'hF;
        rd_addr = {5'd25, 5'd9};
        #1;
        chk("clr_nobypass", rd_data[31:0], RV);
        chk("clr_partial", rd_data[63:32], 32'd75);
      end
      tick();
      drive_idle();
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("clr_done_count", 32'(done_cnt), 32'd1);
    chk("clr_done_cycle", 32'(done_cyc), 32'd33);
    model_reset();
    check_all("clr");

    // Write accepted in DONE-adjacent idle and reset mid-clear
    write_reg(5'd30, 32'h0000_1234);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (9) tick();
    rd_addr = {5'd30, 5'd30};
    #1;
    chk("midclr_pre", rd_data[31:0], 32'h0000_1234);
    chk("midclr_busy_pre", {31'h0, clear_busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("midclr_busy", {31'h0, clear_busy}, 32'h0);
    chk("midclr_done", {31'h0, clear_done}, 32'h0);
    model_reset();
    chk("midclr_r30", rd_data[31:0], RV);
    tick();
    reset_n = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (clear_done || clear_busy) bad_cnt++;
      tick();
    end
    chk("midclr_no_done", 32'(bad_cnt), 32'd0);
    check_all("midclr");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the single-write, dual-read CPU register file.
- Width, depth and read-port count are configurable.
- Adds optional write-to-read bypass, per-byte write enables, and a hardware bulk-clear sequencer with a busy/done handshake.
- Sits in the datapath between instruction decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width.
- NUM_RD, 2, number of read ports, 1..4.
- RESET_VALUE, 32'h0000_0040, value loaded into every register by reset and by bulk clear.
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports; 0 = reads show array contents only.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data; port i uses bits [i*DATA_W +: DATA_W]
- wr_en  in  1  write request (RegWrite)
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_be  in  DATA_W/8  byte enables; bit b covers bits [8b+7:8b]
- clear_req  in  1  bulk-clear request, sampled on the clock edge
- clear_busy  out  1  clear sequencer active; writes are dropped while high
- clear_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (reset_n=0, async): every register = RESET_VALUE; FSM=IDLE; clear_busy=0; clear_done=0; clear index=0. rd_data therefore shows RESET_VALUE on all ports during and after reset.
- Read: combinational, zero latency. rd_data[i] = array[rd_addr[i]].
- Bypass: applies when BYPASS=1 and wr_en=1 and clear_busy=0 and wr_addr==rd_addr[i].
  - Bytes with wr_be=1 show wr_data.
  - Bytes with wr_be=0 show array contents.
- Write: on posedge clk, when wr_en=1 and clear_busy=0, update only the bytes of array[wr_addr] whose wr_be bit is 1. wr_be=0 on all bits is a legal no-op.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: clear_req=1 -> CLEAR, index<=0.
  - CLEAR: clear_busy=1. Each cycle writes RESET_VALUE to array[index] and increments index. When index==DEPTH-1 that register is written and the FSM -> DONE.
  - DONE: clear_done=1, clear_busy=0, one cycle, then -> IDLE. Normal writes are accepted in DONE.
- Clear latency: clear_req sampled at edge 0; registers cleared at edges 1..DEPTH; clear_done high for the cycle after edge DEPTH; clear_busy high for exactly DEPTH cycles.
- clear_req while in CLEAR or DONE: ignored, no queuing.
- Writes during CLEAR: silently dropped; the caller must stall on clear_busy.
- Reads during CLEAR: return current array contents, which may be partly cleared. No bypass.
- Read and write to the same address in one cycle with BYPASS=0: read returns the old value.
- Reset asserted mid-clear: immediate return to IDLE; array = RESET_VALUE; clear_done is never pulsed.
- Index counter is ADDR_W bits wide and wraps only via reset or a new clear. There is no out-of-range address because DEPTH is a power of two.

Optional Feature:
- Macro REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to zero: writes to address 0 are ignored and reads of address 0 return 0, including bypass.
  - Reset and clear leave it at 0.
- Undefined: register 0 behaves like every other register, including reset to RESET_VALUE.

Test Plan:
- Reset, with defaults: assert reset_n=0 mid-simulation, release -> all rd ports read 32'h40 at every address. Without REGFILE_R0_ZERO_EN, address 0 also reads 32'h40.
- Byte-masked write: write 32'hDEAD_BEEF to reg 5 with wr_be=4'b1111, then 32'h1122_3344 with wr_be=4'b0101 -> reg 5 reads 32'hDE22_BE44.
- Bypass (BYPASS=1): wr_en=1, wr_addr=7, wr_data=32'hA5A5_A5A5, rd_addr[0]=7 in the same cycle -> rd_data[0]=32'hA5A5_A5A5 before the edge. With BYPASS=0 -> 32'h40 until after the edge.
- Bulk clear: fill regs 0..31 with index*3, pulse clear_req -> clear_busy high for exactly 32 cycles, clear_done one-cycle pulse, all regs 32'h40. A write to reg 9 during busy is dropped.
- Reset mid-clear: reset_n low at cycle 10 of a clear -> clear_busy=0 immediately, no clear_done, all regs 32'h40.
- With REGFILE_R0_ZERO_EN: write 32'hFFFF_FFFF to reg 0 with rd_addr[1]=0 -> rd_data[1]=0 both in the same cycle and after the edge.
